pim_mac_array: RTL
==================

PIM_MAC_ARRAY -- requirements
Module: pim_mac_array

Interface
REQ-001 Parameter AWIDTH, default 2: row address width; rows PDEPTH = 2**AWIDTH.
REQ-002 Parameter PWIDTH, default 4: weight width; column i has binary significance 2**i.
REQ-003 Parameter IWIDTH, default 4: activation width per row, processed bit-serially.
REQ-004 Parameter DWIDTH, default 16: MAC result width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 mem_addr  input  AWIDTH  row address for memory access.
REQ-008 mem_wdata  input  PWIDTH  write data.
REQ-009 mem_we  input  1  write strobe.
REQ-010 mem_re  input  1  read strobe.
REQ-011 mem_rdata  output  PWIDTH  registered read data.
REQ-012 mem_rvalid  output  1  one-cycle pulse qualifying mem_rdata.
REQ-013 act_data  input  PDEPTH*IWIDTH  activations; row j occupies bits [j*IWIDTH +: IWIDTH].
REQ-014 start  input  1  MAC request.
REQ-015 busy  output  1  high in COMPUTE and DONE.
REQ-016 res_data  output  DWIDTH  MAC result.
REQ-017 res_valid  output  1  result valid.
REQ-018 res_ready  input  1  consumer accept.

Function
REQ-019 FSM states IDLE, COMPUTE, DONE; IDLE after reset.
REQ-020 In IDLE only: mem_we high writes mem_wdata to mem[mem_addr]; mem_re high (mem_we low) loads mem[mem_addr] into mem_rdata and pulses mem_rvalid the next cycle.
REQ-021 mem_we and mem_re together: write performed, no read, no mem_rvalid.
REQ-022 mem_we/mem_re in COMPUTE or DONE are ignored; memory is unchanged.
REQ-023 start in IDLE: captures act_data into an internal register, clears accumulator and plane counter, enters COMPUTE; start has priority over a simultaneous memory access, which is dropped.
REQ-024 COMPUTE, plane k = 0..IWIDTH-1, one plane per cycle: acc += (sum over i of popcount_j(mem[j][i] & act[j][k]) * 2**i) * 2**k.
REQ-025 After plane IWIDTH-1, enter DONE; res_valid rises IWIDTH edges after the start-accepting edge.
REQ-026 Arithmetic unsigned, internal sums at least DWIDTH bits; res_data = true result mod 2**DWIDTH.
REQ-027 DONE holds res_data and res_valid stable until res_valid & res_ready at an edge, then returns to IDLE with res_valid low.
REQ-028 start outside IDLE is ignored.
REQ-029 Memory contents are used as held at each plane cycle; writes cannot occur during COMPUTE.

Reset
REQ-030 rst_n low: FSM to IDLE; busy, res_valid, mem_rvalid 0; res_data, mem_rdata, accumulator, plane counter 0, immediately and without clk.
REQ-031 Memory array is not reset; contents survive reset, including reset mid-COMPUTE, which aborts with no result.

Configuration
REQ-032 Macro PIM_SIGNED_ACT_EN defined: activations two's complement; plane IWIDTH-1 contribution subtracted instead of added; res_data sign-wrapped mod 2**DWIDTH.
REQ-033 Macro undefined: activations unsigned, all planes added.

Verification (AWIDTH=2, PWIDTH=4, IWIDTH=4, DWIDTH=16)
REQ-034 Write mem[1]=4'hA, then read addr 1 -> mem_rdata=4'hA with mem_rvalid one cycle after read strobe; no rvalid for simultaneous we/re.
REQ-035 mem={3,5,0,0}, act={2,1,7,9}, start -> res_data=11, res_valid 4 edges after start edge, busy high throughout.
REQ-036 All rows 4'hF, all act 4'hF -> res_data=900; res_ready held low 5 cycles keeps 900 and res_valid stable; start during busy ignored.
REQ-037 mem[0]=3, others 0, act[0]=4'hF -> 16'hFFFD with PIM_SIGNED_ACT_EN, 45 without.
REQ-038 rst_n low at second COMPUTE cycle -> outputs 0 at once, IDLE, no res_valid; subsequent read of mem[0] returns pre-reset value.

Source files
------------

// File: rtl/pim_mac_array.sv
// Processing-in-memory MAC array: small weight memory with bit-serial activation MAC.
// Define PIM_SIGNED_ACT_EN to treat activations as two's complement.
module pim_mac_array #(
    parameter int AWIDTH = 2,
    parameter int PWIDTH = 4,
    parameter int IWIDTH = 4,
    parameter int DWIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [AWIDTH-1:0]                mem_addr,
    input  logic [PWIDTH-1:0]                mem_wdata,
    input  logic                             mem_we,
    input  logic                             mem_re,
    output logic [PWIDTH-1:0]                mem_rdata,
    output logic                             mem_rvalid,
    input  logic [(2**AWIDTH)*IWIDTH-1:0]    act_data,
    input  logic                             start,
    output logic                             busy,
    output logic [DWIDTH-1:0]                res_data,
    output logic                             res_valid,
    input  logic                             res_ready
);
    localparam int PDEPTH = 2**AWIDTH;
    localparam int CW     = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                     state_q, state_d;
    logic [PWIDTH-1:0]          mem [PDEPTH];
    logic [PDEPTH*IWIDTH-1:0]   act_q;
    logic [DWIDTH-1:0]          acc_q;
    logic [DWIDTH-1:0]          plane_sum;
    logic [DWIDTH-1:0]          plane_term;
    logic [CW-1:0]              plane_q;
    logic                       start_ok, mem_wr, mem_rd, last_plane;

    always_comb begin
        start_ok   = (state_q == IDLE) && start;
        mem_wr     = (state_q == IDLE) && mem_we && !start;
        mem_rd     = (state_q == IDLE) && mem_re && !mem_we && !start;
        last_plane = (plane_q == CW'(IWIDTH - 1));
    end

    // Sum over rows of weight * activation bit equals the column-weighted popcount.
    always_comb begin
        plane_sum = '0;
        for (int unsigned j = 0; j < PDEPTH; j++) begin
            if (act_q[j*IWIDTH + 32'(plane_q)])
                plane_sum = plane_sum + DWIDTH'(mem[j]);
        end
        plane_term = plane_sum << plane_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COMPUTE;
            COMPUTE: if (last_plane) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            act_q      <= '0;
            acc_q      <= '0;
            plane_q    <= '0;
            mem_rdata  <= '0;
            mem_rvalid <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_rvalid <= mem_rd;
            if (mem_rd)
                mem_rdata <= mem[mem_addr];
            if (start_ok) begin
                act_q   <= act_data;
                acc_q   <= '0;
                plane_q <= '0;
            end else if (state_q == COMPUTE) begin
                plane_q <= plane_q + CW'(1);
`ifdef PIM_SIGNED_ACT_EN
                if (last_plane)
                    acc_q <= acc_q - plane_term;
                else
                    acc_q <= acc_q + plane_term;
`else
                acc_q <= acc_q + plane_term;
`endif
            end
        end
    end

    // Weight memory intentionally has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[mem_addr] <= mem_wdata;
    end

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign res_data  = acc_q;

endmodule
